// File: rtl/tt_um_ternary_sequencer.sv
// Command sequencer for the ternary matrix-vector engine: decodes bus opcodes
// and schedules weight load, multiply and result drain with bounded counters.
module tt_um_ternary_sequencer #(
    parameter int MAX_IN_LEN  = 16,
    parameter int MAX_OUT_LEN = 8,
    parameter int LOAD_WORDS  = 2*MAX_IN_LEN*MAX_OUT_LEN/16,
    parameter int MULT_CYCLES = 1
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic [15:0]                    ui_input,
    input  logic                           load_done,
    output logic                           load_ena,
    output logic                           mult_ena,
    output logic                           out_valid,
    output logic [$clog2(MAX_OUT_LEN)-1:0] out_idx,
    output logic                           weights_valid,
    output logic                           err,
    output logic                           busy,
    output logic [1:0]                     state
);
    localparam int IDX_W   = $clog2(MAX_OUT_LEN);
    localparam int CNT_MAX = (LOAD_WORDS > MULT_CYCLES) ?
                             ((LOAD_WORDS > MAX_OUT_LEN) ? LOAD_WORDS : MAX_OUT_LEN) :
                             ((MULT_CYCLES > MAX_OUT_LEN) ? MULT_CYCLES : MAX_OUT_LEN);
    localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

    localparam logic [CNT_W-1:0] LOAD_LAST = CNT_W'(LOAD_WORDS - 1);
    localparam logic [CNT_W-1:0] MULT_LAST = CNT_W'(MULT_CYCLES - 1);
    localparam logic [CNT_W-1:0] OUT_LAST  = CNT_W'(MAX_OUT_LEN - 1);

    localparam logic [3:0] OP_LOAD  = 4'hA;
    localparam logic [3:0] OP_MULT  = 4'hF;
    localparam logic [3:0] OP_ABORT = 4'h5;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_LOAD  = 2'd1,
        S_MULT  = 2'd2,
        S_DRAIN = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             start_q, start_d;
    logic             rpt_q, rpt_d;
    logic             err_d, wv_d;
    logic [3:0]       opcode;

    assign opcode = ui_input[15:12];
    assign state  = state_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= S_IDLE;
            cnt_q         <= '0;
            start_q       <= 1'b0;
            rpt_q         <= 1'b0;
            err           <= 1'b0;
            weights_valid <= 1'b0;
            load_ena      <= 1'b0;
            mult_ena      <= 1'b0;
            out_valid     <= 1'b0;
            out_idx       <= '0;
            busy          <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            start_q       <= start_d;
            rpt_q         <= rpt_d;
            err           <= err_d;
            weights_valid <= wv_d;
            // Strobes are registered from the next state so they line up with it.
            load_ena      <= (state_d == S_LOAD);
            mult_ena      <= (state_d == S_MULT) || (state_d == S_DRAIN);
            out_valid     <= (state_d == S_DRAIN);
            out_idx       <= (state_d == S_DRAIN) ? cnt_d[IDX_W-1:0] : '0;
            busy          <= (state_d != S_IDLE);
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        start_d = start_q;
        rpt_d   = rpt_q;
        err_d   = err;
        wv_d    = weights_valid;
        case (state_q)
            S_IDLE: begin
                case (opcode)
                    OP_LOAD: begin
                        start_d = ui_input[0];
                        rpt_d   = ui_input[1];
                        err_d   = 1'b0;
                        wv_d    = 1'b0;
                        cnt_d   = '0;
                        state_d = S_LOAD;
                    end
                    OP_MULT: begin
                        if (weights_valid) begin
                            rpt_d   = ui_input[1];
                            err_d   = 1'b0;
                            cnt_d   = '0;
                            state_d = S_MULT;
                        end else begin
                            err_d = 1'b1;
                        end
                    end
                    OP_ABORT: err_d = 1'b0;
                    default: ;
                endcase
            end
            S_LOAD: begin
                // Bus carries weight data here; only the loader's flag matters.
                if (cnt_q == LOAD_LAST && load_done) begin
                    wv_d    = 1'b1;
                    cnt_d   = '0;
                    state_d = start_q ? S_MULT : S_IDLE;
                end else if (cnt_q == LOAD_LAST || load_done) begin
                    err_d   = 1'b1;
                    wv_d    = 1'b0;
                    cnt_d   = '0;
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_MULT: begin
                if (cnt_q == MULT_LAST) begin
                    cnt_d   = '0;
                    state_d = S_DRAIN;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_DRAIN: begin
                if (opcode == OP_ABORT) begin
                    rpt_d   = 1'b0;
                    err_d   = 1'b0;
                    cnt_d   = '0;
                    state_d = S_IDLE;
                end else if (cnt_q == OUT_LAST) begin
                    cnt_d   = '0;
                    state_d = rpt_q ? S_MULT : S_IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                cnt_d   = '0;
                state_d = S_IDLE;
            end
        endcase
    end
endmodule

// File: tb/tb_tt_um_ternary_sequencer.sv
// Directed bench for the ternary sequencer: load, multiply, drain, repeat,
// abort, protocol errors and asynchronous reset.
module tb_tt_um_ternary_sequencer;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] ui_input = '0;
    logic        load_done = 1'b0;
    logic        load_ena, mult_ena, out_valid, weights_valid, err, busy;
    logic [2:0]  out_idx;
    logic [1:0]  state;
    int          ncomp = 0;
    int          nfail = 0;

    tt_um_ternary_sequencer dut (
        .clk(clk), .rst_n(rst_n), .ui_input(ui_input), .load_done(load_done),
        .load_ena(load_ena), .mult_ena(mult_ena), .out_valid(out_valid),
        .out_idx(out_idx), .weights_valid(weights_valid), .err(err),
        .busy(busy), .state(state)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        ncomp++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, ".load_ena"}, 16'(load_ena), 16'h0);
        chk({tag, ".mult_ena"}, 16'(mult_ena), 16'h0);
        chk({tag, ".out_valid"}, 16'(out_valid), 16'h0);
        chk({tag, ".out_idx"}, 16'(out_idx), 16'h0);
        chk({tag, ".weights_valid"}, 16'(weights_valid), 16'h0);
        chk({tag, ".err"}, 16'(err), 16'h0);
        chk({tag, ".busy"}, 16'(busy), 16'h0);
        chk({tag, ".state"}, 16'(state), 16'h0);
    endtask

    // Issue a LOAD command, stream data words, pulse load_done on data cycle done_at.
    // Returns positioned in the cycle after that pulse.
    task automatic load_cycles(input logic [15:0] cmd, input int done_at, input string tag);
        ui_input = cmd;
        tick();
        for (int c = 1; c <= done_at; c++) begin
            chk({tag, ".load_ena"}, 16'(load_ena), 16'h1);
            chk({tag, ".state"}, 16'(state), 16'h1);
            chk({tag, ".err"}, 16'(err), 16'h0);
            chk({tag, ".wv_cleared"}, 16'(weights_valid), 16'h0);
            ui_input  = 16'hC3C3 ^ 16'(c);
            load_done = (c == done_at);
            tick();
        end
        load_done = 1'b0;
        ui_input  = '0;
    endtask

    task automatic drain_check(input string tag);
        for (int k = 0; k < 8; k++) begin
            chk({tag, ".state"}, 16'(state), 16'h3);
            chk({tag, ".out_valid"}, 16'(out_valid), 16'h1);
            chk({tag, ".mult_ena"}, 16'(mult_ena), 16'h1);
            chk({tag, ".out_idx"}, 16'(out_idx), 16'(k));
            tick();
        end
    endtask

    initial begin
        // Reset
        tick();
        chk_zero("rst_held");
        rst_n = 1'b1;
        tick();
        chk_zero("rst_idle");

        // MULT before any load is a protocol error
        ui_input = 16'hF000;
        tick();
        ui_input = '0;
        chk("mult_nowv.err", 16'(err), 16'h1);
        chk("mult_nowv.state", 16'(state), 16'h0);
        chk("mult_nowv.mult_ena", 16'(mult_ena), 16'h0);
        tick();
        chk("mult_nowv.err_sticky", 16'(err), 16'h1);
        chk("mult_nowv.mult_ena2", 16'(mult_ena), 16'h0);

        // Plain load: LOAD clears err, 16 load_ena cycles, back to IDLE with weights
        load_cycles(16'hA000, 16, "load0");
        chk("load0.load_ena_off", 16'(load_ena), 16'h0);
        chk("load0.state_end", 16'(state), 16'h0);
        chk("load0.wv", 16'(weights_valid), 16'h1);
        chk("load0.err_end", 16'(err), 16'h0);
        chk("load0.busy_end", 16'(busy), 16'h0);

        // Load with start: 1x16, 2x1, 3x8, 0
        load_cycles(16'hA001, 16, "load1");
        chk("load1.mult_state", 16'(state), 16'h2);
        chk("load1.mult_ena", 16'(mult_ena), 16'h1);
        chk("load1.mult_noval", 16'(out_valid), 16'h0);
        chk("load1.wv", 16'(weights_valid), 16'h1);
        tick();
        drain_check("drain1");
        chk("drain1.idle", 16'(state), 16'h0);
        chk("drain1.outv_off", 16'(out_valid), 16'h0);
        chk("drain1.mena_off", 16'(mult_ena), 16'h0);
        chk("drain1.busy_off", 16'(busy), 16'h0);

        // MULT-only with valid weights: MULT at 1, DRAIN 2..9, IDLE at 10
        ui_input = 16'hF000;
        tick();
        ui_input = '0;
        chk("mulonly.state", 16'(state), 16'h2);
        chk("mulonly.busy", 16'(busy), 16'h1);
        tick();
        drain_check("mulonly");
        chk("mulonly.idle", 16'(state), 16'h0);

        // Repeat mode, then ABORT at drain index 3 of the second drain
        load_cycles(16'hA003, 16, "rpt");
        chk("rpt.mult1", 16'(state), 16'h2);
        tick();
        drain_check("rpt.d1");
        chk("rpt.mult2", 16'(state), 16'h2);
        chk("rpt.mult2_noval", 16'(out_valid), 16'h0);
        tick();
        for (int k = 0; k < 4; k++) begin
            chk("rpt.d2_state", 16'(state), 16'h3);
            chk("rpt.d2_idx", 16'(out_idx), 16'(k));
            if (k == 3) ui_input = 16'h5000;
            tick();
        end
        ui_input = '0;
        chk("abort.out_valid", 16'(out_valid), 16'h0);
        chk("abort.state", 16'(state), 16'h0);
        chk("abort.mult_ena", 16'(mult_ena), 16'h0);
        chk("abort.wv_kept", 16'(weights_valid), 16'h1);
        tick();
        chk("abort.stays_idle", 16'(state), 16'h0);

        // Early load_done at data cycle 5
        load_cycles(16'hA000, 5, "early");
        chk("early.err", 16'(err), 16'h1);
        chk("early.wv", 16'(weights_valid), 16'h0);
        chk("early.state", 16'(state), 16'h0);
        chk("early.load_ena", 16'(load_ena), 16'h0);

        // Good load again, then reset in the middle of a drain
        load_cycles(16'hA000, 16, "reload");
        chk("reload.wv", 16'(weights_valid), 16'h1);
        ui_input = 16'hF000;
        tick();
        ui_input = '0;
        tick();
        tick();
        tick();
        chk("rst_drain.pre_idx", 16'(out_idx), 16'h2);
        rst_n = 1'b0;
        #1;
        chk_zero("rst_drain");
        tick();
        rst_n = 1'b1;
        tick();

        // Reset in the middle of a load (cycle 8)
        ui_input = 16'hA000;
        tick();
        for (int c = 1; c < 8; c++) begin
            ui_input = 16'h0F0F;
            tick();
        end
        chk("rst_load.pre_state", 16'(state), 16'h1);
        rst_n = 1'b0;
        #1;
        chk_zero("rst_load");
        tick();
        rst_n = 1'b1;
        ui_input = '0;
        tick();

        // Unknown opcode in IDLE is ignored
        ui_input = 16'h3000;
        tick();
        ui_input = '0;
        chk_zero("unknown_op");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncomp, nfail);
        $finish;
    end
endmodule
